// File: rtl/csr_uart_fifo.sv
// csr_uart_fifo: CSR-mapped UART with TX and RX byte FIFOs.
//
// Optional feature macro: CSR_UART_FIFO_IRQ_EN. When defined, the interrupt
// enables in the control register and the registered irq output are built.
// When it is undefined, irq is tied low, the enable bits read 0 and writes to
// them are ignored.
//
// Registers:
//   BASE_ADDR   data/status. Read: [7:0] RX head byte (0 when empty),
//               [8] rx_empty, [9] tx_full, [10] rx_overrun, [11] tx_idle.
//               write pushes wdata[7:0] to TX, set pops RX,
//               clear with wdata[10]=1 clears rx_overrun.
//   BASE_ADDR+1 control. Read: [15:0] DIV (cycles per bit), [17:16] enables.
//               write loads DIV (clamped to >= 4) and enables; set/clear
//               touch the enables only.
//
// Ports:
//   clk, rstn   clock, asynchronous active-low reset
//   read        CSR read strobe (unused; reads are decoded from addr alone)
//   modify      001 write, 010 set, 011 clear, others no-op
//   wdata, addr CSR write data and address
//   rdata       registered read data, pre-modify value (0 on a miss)
//   valid       registered address hit
//   rx, tx      serial in / out
//   irq         interrupt request
module csr_uart_fifo #(
  parameter logic [11:0] BASE_ADDR  = 12'hbc0,
  parameter int unsigned CLOCK_RATE = 12_000_000,
  parameter int unsigned BAUD_RATE  = 115200,
  parameter int unsigned TX_DEPTH   = 8,
  parameter int unsigned RX_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        read,
  input  logic [2:0]  modify,
  input  logic [31:0] wdata,
  input  logic [11:0] addr,
  output logic [31:0] rdata,
  output logic        valid,
  input  logic        rx,
  output logic        tx,
  output logic        irq
);

  localparam int unsigned TxAw    = $clog2(TX_DEPTH);
  localparam int unsigned RxAw    = $clog2(RX_DEPTH);
  localparam int unsigned DivFull = CLOCK_RATE / BAUD_RATE;
  localparam logic [15:0] DivInit = 16'(DivFull);
  localparam logic [15:0] DivMin  = 16'd4;

  localparam logic [2:0] OpWrite = 3'b001;
  localparam logic [2:0] OpSet   = 3'b010;
  localparam logic [2:0] OpClear = 3'b011;

  localparam logic [TxAw:0] TxOne = {{TxAw{1'b0}}, 1'b1};
  localparam logic [RxAw:0] RxOne = {{RxAw{1'b0}}, 1'b1};

  typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} tx_state_e;
  typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;

  logic unused_in;
  assign unused_in = ^{read, wdata[31:16]};

  // ---------------------------------------------------------------------------
  // CSR decode
  // ---------------------------------------------------------------------------
  logic hit_data, hit_ctrl;
  logic op_write, op_set, op_clear;

  assign hit_data = (addr == BASE_ADDR);
  assign hit_ctrl = (addr == BASE_ADDR + 12'd1);
  assign op_write = (modify == OpWrite);
  assign op_set   = (modify == OpSet);
  assign op_clear = (modify == OpClear);

  logic [15:0] div_q;
  logic [1:0]  en;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      div_q <= DivInit;
    end else if (hit_ctrl && op_write) begin
      div_q <= (wdata[15:0] < DivMin) ? DivMin : wdata[15:0];
    end
  end

  // ---------------------------------------------------------------------------
  // TX FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]    tx_mem [TX_DEPTH];
  logic [TxAw:0] tx_wptr_q, tx_rptr_q;
  logic          tx_empty, tx_full, tx_push, tx_pop;
  logic [7:0]    tx_head;

  assign tx_empty = (tx_wptr_q == tx_rptr_q);
  assign tx_full  = (tx_wptr_q[TxAw] != tx_rptr_q[TxAw]) &&
                    (tx_wptr_q[TxAw-1:0] == tx_rptr_q[TxAw-1:0]);
  assign tx_head  = tx_mem[tx_rptr_q[TxAw-1:0]];
  // A full FIFO drops the byte even if the shifter pops in the same cycle.
  assign tx_push  = hit_data && op_write && !tx_full;

  always_ff @(posedge clk) begin
    if (tx_push) begin
      tx_mem[tx_wptr_q[TxAw-1:0]] <= wdata[7:0];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tx_wptr_q <= '0;
      tx_rptr_q <= '0;
    end else begin
      if (tx_push) tx_wptr_q <= tx_wptr_q + TxOne;
      if (tx_pop)  tx_rptr_q <= tx_rptr_q + TxOne;
    end
  end

  // ---------------------------------------------------------------------------
  // TX shifter
  // ---------------------------------------------------------------------------
  tx_state_e   tx_state_q;
  logic [15:0] tx_cnt_q, tx_div_q;
  logic [7:0]  tx_shift_q;
  logic [2:0]  tx_bit_q;
  logic        tx_q;
  logic        tx_bit_end, tx_idle;

  // Each bit latches DIV when it starts, so a DIV write lands on a bit boundary.
  assign tx_bit_end = (tx_cnt_q == tx_div_q - 16'd1);
  assign tx_pop     = !tx_empty &&
                      ((tx_state_q == TxIdle) || ((tx_state_q == TxStop) && tx_bit_end));
  assign tx_idle    = tx_empty && (tx_state_q == TxIdle);
  assign tx         = tx_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tx_state_q <= TxIdle;
      tx_cnt_q   <= '0;
      tx_div_q   <= DivInit;
      tx_shift_q <= '0;
      tx_bit_q   <= '0;
      tx_q       <= 1'b1;
    end else begin
      case (tx_state_q)
        TxIdle: begin
          if (!tx_empty) begin
            tx_state_q <= TxStart;
            tx_shift_q <= tx_head;
            tx_q       <= 1'b0;
            tx_cnt_q   <= '0;
            tx_div_q   <= div_q;
          end
        end
        TxStart: begin
          if (tx_bit_end) begin
            tx_state_q <= TxData;
            tx_q       <= tx_shift_q[0];
            tx_bit_q   <= '0;
            tx_cnt_q   <= '0;
            tx_div_q   <= div_q;
          end else begin
            tx_cnt_q <= tx_cnt_q + 16'd1;
          end
        end
        TxData: begin
          if (tx_bit_end) begin
            tx_cnt_q <= '0;
            tx_div_q <= div_q;
            if (tx_bit_q == 3'd7) begin
              tx_state_q <= TxStop;
              tx_q       <= 1'b1;
            end else begin
              tx_bit_q   <= tx_bit_q + 3'd1;
              tx_shift_q <= {1'b0, tx_shift_q[7:1]};
              tx_q       <= tx_shift_q[1];
            end
          end else begin
            tx_cnt_q <= tx_cnt_q + 16'd1;
          end
        end
        TxStop: begin
          if (tx_bit_end) begin
            tx_cnt_q <= '0;
            tx_div_q <= div_q;
            // Chain straight into the next start bit when more data is queued.
            if (!tx_empty) begin
              tx_state_q <= TxStart;
              tx_shift_q <= tx_head;
              tx_q       <= 1'b0;
            end else begin
              tx_state_q <= TxIdle;
            end
          end else begin
            tx_cnt_q <= tx_cnt_q + 16'd1;
          end
        end
        default: begin
          tx_state_q <= TxIdle;
          tx_q       <= 1'b1;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // RX synchroniser and receiver
  // ---------------------------------------------------------------------------
  logic [1:0]  rx_sync_q;
  logic        rx_s, rx_prev_q;
  rx_state_e   rx_state_q;
  logic [15:0] rx_cnt_q, rx_div_q;
  logic [7:0]  rx_shift_q;
  logic [2:0]  rx_bit_q;
  logic        rx_half_end, rx_bit_end, rx_push;

  assign rx_s        = rx_sync_q[1];
  assign rx_half_end = (rx_cnt_q == {1'b0, rx_div_q[15:1]} - 16'd1);
  assign rx_bit_end  = (rx_cnt_q == rx_div_q - 16'd1);
  // Frames with a low stop bit are dropped without any status.
  assign rx_push     = (rx_state_q == RxStop) && rx_bit_end && rx_s;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_sync_q <= 2'b11;
      rx_prev_q <= 1'b1;
    end else begin
      rx_sync_q <= {rx_sync_q[0], rx};
      rx_prev_q <= rx_s;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_state_q <= RxIdle;
      rx_cnt_q   <= '0;
      rx_div_q   <= DivInit;
      rx_shift_q <= '0;
      rx_bit_q   <= '0;
    end else begin
      case (rx_state_q)
        RxIdle: begin
          if (rx_prev_q && !rx_s) begin
            rx_state_q <= RxStart;
            rx_cnt_q   <= '0;
            rx_div_q   <= div_q;
          end
        end
        RxStart: begin
          if (rx_half_end) begin
            rx_cnt_q <= '0;
            if (rx_s) begin
              rx_state_q <= RxIdle;
            end else begin
              rx_state_q <= RxData;
              rx_bit_q   <= '0;
              rx_div_q   <= div_q;
            end
          end else begin
            rx_cnt_q <= rx_cnt_q + 16'd1;
          end
        end
        RxData: begin
          if (rx_bit_end) begin
            rx_shift_q <= {rx_s, rx_shift_q[7:1]};
            rx_cnt_q   <= '0;
            rx_div_q   <= div_q;
            if (rx_bit_q == 3'd7) begin
              rx_state_q <= RxStop;
            end else begin
              rx_bit_q <= rx_bit_q + 3'd1;
            end
          end else begin
            rx_cnt_q <= rx_cnt_q + 16'd1;
          end
        end
        RxStop: begin
          if (rx_bit_end) begin
            rx_state_q <= RxIdle;
            rx_cnt_q   <= '0;
          end else begin
            rx_cnt_q <= rx_cnt_q + 16'd1;
          end
        end
        default: rx_state_q <= RxIdle;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // RX FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]    rx_mem [RX_DEPTH];
  logic [RxAw:0] rx_wptr_q, rx_rptr_q;
  logic          rx_empty, rx_full, rx_pop, rx_do_push;
  logic          rx_overrun_q;
  logic [7:0]    rx_head;

  assign rx_empty   = (rx_wptr_q == rx_rptr_q);
  assign rx_full    = (rx_wptr_q[RxAw] != rx_rptr_q[RxAw]) &&
                      (rx_wptr_q[RxAw-1:0] == rx_rptr_q[RxAw-1:0]);
  assign rx_head    = rx_empty ? 8'h00 : rx_mem[rx_rptr_q[RxAw-1:0]];
  assign rx_pop     = hit_data && op_set && !rx_empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign rx_do_push = rx_push && (!rx_full || rx_pop);

  always_ff @(posedge clk) begin
    if (rx_do_push) begin
      rx_mem[rx_wptr_q[RxAw-1:0]] <= rx_shift_q;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_wptr_q    <= '0;
      rx_rptr_q    <= '0;
      rx_overrun_q <= 1'b0;
    end else begin
      if (rx_do_push) rx_wptr_q <= rx_wptr_q + RxOne;
      if (rx_pop)     rx_rptr_q <= rx_rptr_q + RxOne;
      if (rx_push && !rx_do_push) begin
        rx_overrun_q <= 1'b1;
      end else if (hit_data && op_clear && wdata[10]) begin
        rx_overrun_q <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Interrupts
  // ---------------------------------------------------------------------------
`ifdef CSR_UART_FIFO_IRQ_EN
  logic [1:0] en_q;
  logic       irq_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      en_q  <= 2'b00;
      irq_q <= 1'b0;
    end else begin
      if (hit_ctrl && op_write) begin
        en_q <= wdata[17:16];
      end else if (hit_ctrl && op_set) begin
        en_q <= en_q | wdata[17:16];
      end else if (hit_ctrl && op_clear) begin
        en_q <= en_q & ~wdata[17:16];
      end
      irq_q <= (en_q[0] & ~rx_empty) | (en_q[1] & tx_idle) | (en_q[0] & rx_overrun_q);
    end
  end

  assign en  = en_q;
  assign irq = irq_q;
`else
  assign en  = 2'b00;
  assign irq = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Registered read port
  // ---------------------------------------------------------------------------
  logic [31:0] data_val, ctrl_val;
  logic [31:0] rdata_q;
  logic        valid_q;

  assign data_val = {20'd0, tx_idle, rx_overrun_q, tx_full, rx_empty, rx_head};
  assign ctrl_val = {14'd0, en, div_q};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rdata_q <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= hit_data || hit_ctrl;
      if (hit_data) begin
        rdata_q <= data_val;
      end else if (hit_ctrl) begin
        rdata_q <= ctrl_val;
      end else begin
        rdata_q <= '0;
      end
    end
  end

  assign rdata = rdata_q;
  assign valid = valid_q;

endmodule
